// File: rtl/mips_ctrl_seq.sv
// Multicycle MIPS control sequencer: FETCH/EXEC1/EXEC2/HALT with waitrequest stalls.
// Optional wait timeout fault enabled by defining CTRL_WAIT_TIMEOUT_EN.
module mips_ctrl_seq #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode_i,
    input  logic [5:0] function_i,
    input  logic [4:0] regimm_i,
    input  logic       b_cond_met_i,
    input  logic [1:0] addr_lsb_i,
    input  logic       waitrequest_i,
    input  logic       halt_req_i,
    output logic [1:0] state_o,
    output logic       pc_write_en_o,
    output logic       ir_write_en_o,
    output logic       ram_write_en_o,
    output logic       ram_read_en_o,
    output logic       ram_addr_sel_o,
    output logic       src_b_sel_o,
    output logic       regfile_write_en_o,
    output logic [3:0] ram_byte_en_o,
    output logic [1:0] regfile_addr_3_sel_o,
    output logic       active_o,
    output logic       fault_o
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC1 = 2'd1;
    localparam logic [1:0] S_EXEC2 = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [1:0] SEL_RT  = 2'd0;
    localparam logic [1:0] SEL_RD  = 2'd1;
    localparam logic [1:0] SEL_31  = 2'd2;

    logic [1:0] state, nxt;
    logic       fault, first, set_fault;
    logic       is_load, is_store, is_w, is_h, is_b;
    logic       is_imm, is_jal, is_link, is_jalr, rd_wr;
    logic       misalign, mem_req, timeout, reg_wr;
    logic [3:0] lanes;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_w     = 1'b0;
        is_h     = 1'b0;
        is_b     = 1'b0;
        is_imm   = 1'b0;
        is_jal   = 1'b0;
        is_link  = 1'b0;
        is_jalr  = 1'b0;
        rd_wr    = 1'b0;
        case (opcode_i)
            6'b100011: begin is_load = 1'b1; is_w = 1'b1; end
            6'b100001,
            6'b100101: begin is_load = 1'b1; is_h = 1'b1; end
            6'b100000,
            6'b100100: begin is_load = 1'b1; is_b = 1'b1; end
            6'b101011: begin is_store = 1'b1; is_w = 1'b1; end
            6'b101001: begin is_store = 1'b1; is_h = 1'b1; end
            6'b101000: begin is_store = 1'b1; is_b = 1'b1; end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111:
                is_imm = 1'b1;
            6'b000011: is_jal = 1'b1;
            6'b000001:
                is_link = (regimm_i == 5'b10000) ||
                          (regimm_i == 5'b10001);
            6'b000000: begin
                case (function_i)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h10, 6'h12,
                    6'h20, 6'h21, 6'h22, 6'h23,
                    6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2a, 6'h2b:
                        rd_wr = 1'b1;
                    6'h09: is_jalr = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        lanes = 4'b1111;
        if (is_h)
            lanes = 4'b0011 << addr_lsb_i;
        else if (is_b)
            lanes = 4'b0001 << addr_lsb_i;
    end

    assign misalign = (is_w && addr_lsb_i != 2'b00) ||
                      (is_h && addr_lsb_i[0]);

    assign reg_wr = is_load | is_imm | rd_wr |
                    ((is_jalr | is_jal | is_link) & b_cond_met_i);

    // RAM request per state, independent of the output logic below
    assign mem_req = (state == S_FETCH) ||
                     (state == S_EXEC1 && is_load && !misalign) ||
                     (state == S_EXEC2 && is_store && !misalign);

`ifdef CTRL_WAIT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    assign timeout = waitrequest_i && mem_req && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset || nxt != state || !waitrequest_i)
            wait_cnt <= '0;
        else if (mem_req)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^CNT_W'(TIMEOUT_CYCLES);
    assign timeout    = 1'b0;
`endif

    always_comb begin
        nxt                  = state;
        set_fault            = 1'b0;
        pc_write_en_o        = 1'b0;
        ir_write_en_o        = 1'b0;
        ram_write_en_o       = 1'b0;
        ram_read_en_o        = 1'b0;
        ram_addr_sel_o       = 1'b0;
        src_b_sel_o          = 1'b0;
        regfile_write_en_o   = 1'b0;
        ram_byte_en_o        = 4'b0000;
        regfile_addr_3_sel_o = SEL_RT;
        case (state)
            S_FETCH: begin
                ram_read_en_o = 1'b1;
                ram_byte_en_o = 4'b1111;
                if (!waitrequest_i)
                    nxt = S_EXEC1;
            end
            S_EXEC1: begin
                ir_write_en_o = first;
                if (is_load && misalign) begin
                    set_fault = 1'b1;
                    nxt       = S_HALT;
                end else if (is_load) begin
                    ram_read_en_o  = 1'b1;
                    ram_addr_sel_o = 1'b1;
                    src_b_sel_o    = 1'b1;
                    ram_byte_en_o  = lanes;
                    if (!waitrequest_i)
                        nxt = S_EXEC2;
                end else begin
                    nxt = S_EXEC2;
                end
            end
            S_EXEC2: begin
                if (is_link || is_jal)
                    regfile_addr_3_sel_o = SEL_31;
                else if (rd_wr || is_jalr)
                    regfile_addr_3_sel_o = SEL_RD;
                src_b_sel_o = is_imm;
                if (is_store && misalign) begin
                    set_fault = 1'b1;
                    nxt       = S_HALT;
                end else begin
                    if (is_store) begin
                        ram_write_en_o = 1'b1;
                        ram_addr_sel_o = 1'b1;
                        src_b_sel_o    = 1'b1;
                        ram_byte_en_o  = lanes;
                    end
                    if (!is_store || !waitrequest_i) begin
                        pc_write_en_o      = 1'b1;
                        regfile_write_en_o = reg_wr;
                        nxt = halt_req_i ? S_HALT : S_FETCH;
                    end
                end
            end
            default: ;
        endcase
        if (timeout) begin
            pc_write_en_o      = 1'b0;
            regfile_write_en_o = 1'b0;
            set_fault          = 1'b1;
            nxt                = S_HALT;
        end
        // nothing leaves the block during the reset cycle
        if (reset) begin
            pc_write_en_o      = 1'b0;
            ir_write_en_o      = 1'b0;
            ram_write_en_o     = 1'b0;
            ram_read_en_o      = 1'b0;
            ram_addr_sel_o     = 1'b0;
            src_b_sel_o        = 1'b0;
            regfile_write_en_o = 1'b0;
            ram_byte_en_o      = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            fault <= 1'b0;
            first <= 1'b1;
        end else begin
            state <= nxt;
            fault <= fault | set_fault;
            first <= (nxt != state);
        end
    end

    assign state_o  = state;
    assign fault_o  = fault;
    assign active_o = (state != S_HALT);

endmodule

// File: tb/tb_mips_ctrl_seq.sv
// Scoreboard bench for mips_ctrl_seq: directed per-cycle vectors, decoupled monitor.
// Exercises the CTRL_WAIT_TIMEOUT_EN build when that macro is defined.
module tb_mips_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode_i = '0;
    logic [5:0] function_i = '0;
    logic [4:0] regimm_i = '0;
    logic       b_cond_met_i = 1'b0;
    logic [1:0] addr_lsb_i = '0;
    logic       waitrequest_i = 1'b0;
    logic       halt_req_i = 1'b0;
    logic [1:0] state_o;
    logic       pc_write_en_o, ir_write_en_o, ram_write_en_o;
    logic       ram_read_en_o, ram_addr_sel_o, src_b_sel_o;
    logic       regfile_write_en_o;
    logic [3:0] ram_byte_en_o;
    logic [1:0] regfile_addr_3_sel_o;
    logic       active_o, fault_o;

    always #5 clk = ~clk;

    mips_ctrl_seq #(.TIMEOUT_CYCLES(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .opcode_i             (opcode_i),
        .function_i           (function_i),
        .regimm_i             (regimm_i),
        .b_cond_met_i         (b_cond_met_i),
        .addr_lsb_i           (addr_lsb_i),
        .waitrequest_i        (waitrequest_i),
        .halt_req_i           (halt_req_i),
        .state_o              (state_o),
        .pc_write_en_o        (pc_write_en_o),
        .ir_write_en_o        (ir_write_en_o),
        .ram_write_en_o       (ram_write_en_o),
        .ram_read_en_o        (ram_read_en_o),
        .ram_addr_sel_o       (ram_addr_sel_o),
        .src_b_sel_o          (src_b_sel_o),
        .regfile_write_en_o   (regfile_write_en_o),
        .ram_byte_en_o        (ram_byte_en_o),
        .regfile_addr_3_sel_o (regfile_addr_3_sel_o),
        .active_o             (active_o),
        .fault_o              (fault_o)
    );

    // enable vector order: {pc, ir, ram_wr, ram_rd, addr_sel, src_b, rf_wr}
    localparam logic [6:0] NO = 7'b0000000;
    localparam logic [6:0] PC = 7'b1000000;
    localparam logic [6:0] IR = 7'b0100000;
    localparam logic [6:0] RW = 7'b0010000;
    localparam logic [6:0] RR = 7'b0001000;
    localparam logic [6:0] AS = 7'b0000100;
    localparam logic [6:0] SB = 7'b0000010;
    localparam logic [6:0] RF = 7'b0000001;

    typedef struct {
        logic [1:0] st;
        logic [6:0] en;
        logic [3:0] be;
        logic [1:0] sel;
        logic       act;
        logic       flt;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;

    logic [5:0] nx_op = '0;
    logic [5:0] nx_fn = '0;
    logic [4:0] nx_rt = '0;
    logic       nx_bc = 1'b0;
    logic [1:0] nx_lsb = '0;

    task automatic instr(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rt, input logic bc,
                         input logic [1:0] lsb);
        nx_op  = op;
        nx_fn  = fn;
        nx_rt  = rt;
        nx_bc  = bc;
        nx_lsb = lsb;
    endtask

    task automatic cyc(input logic rst, input logic wr, input logic hr,
                       input logic [1:0] st, input logic [6:0] en,
                       input logic [3:0] be, input logic [1:0] sel,
                       input logic flt, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        waitrequest_i = wr;
        halt_req_i    = hr;
        opcode_i      = nx_op;
        function_i    = nx_fn;
        regimm_i      = nx_rt;
        b_cond_met_i  = nx_bc;
        addr_lsb_i    = nx_lsb;
        e.st  = st;
        e.en  = en;
        e.be  = be;
        e.sel = sel;
        e.act = (st != 2'd3);
        e.flt = flt;
        e.nm  = nm;
        q.push_back(e);
    endtask

    initial begin
        logic [6:0] got;
        logic       ok;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                me  = q.pop_front();
                got = {pc_write_en_o, ir_write_en_o, ram_write_en_o,
                       ram_read_en_o, ram_addr_sel_o, src_b_sel_o,
                       regfile_write_en_o};
                ok  = (state_o == me.st) && (got == me.en) &&
                      (ram_byte_en_o == me.be) &&
                      (active_o == me.act) && (fault_o == me.flt) &&
                      (!me.en[0] || regfile_addr_3_sel_o == me.sel);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL %s: got st=%0d en=%b be=%b sel=%0d act=%b flt=%b want st=%0d en=%b be=%b sel=%0d act=%b flt=%b",
                             me.nm, state_o, got, ram_byte_en_o,
                             regfile_addr_3_sel_o, active_o, fault_o,
                             me.st, me.en, me.be, me.sel, me.act,
                             me.flt);
                end
            end
        end
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        instr(6'b001001, 6'h00, 5'd0, 1'b0, 2'd0);
        cyc(1, 0, 0, 0, NO, 4'b0000, 0, 0, "reset");
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "addiu_fetch");
        cyc(0, 0, 0, 1, IR, 4'b0000, 0, 0, "addiu_ex1");
        cyc(0, 0, 0, 2, PC | SB | RF, 4'b0000, 0, 0, "addiu_ex2");

        instr(6'b100011, 6'h00, 5'd0, 1'b0, 2'd0);
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "lw_fetch");
        cyc(0, 1, 0, 1, IR | RR | AS | SB, 4'b1111, 0, 0, "lw_ex1_a");
        cyc(0, 1, 0, 1, RR | AS | SB, 4'b1111, 0, 0, "lw_ex1_b");
        cyc(0, 1, 0, 1, RR | AS | SB, 4'b1111, 0, 0, "lw_ex1_c");
        cyc(0, 0, 0, 1, RR | AS | SB, 4'b1111, 0, 0, "lw_ex1_d");
        cyc(0, 0, 0, 2, PC | RF, 4'b0000, 0, 0, "lw_ex2");

        instr(6'b101000, 6'h00, 5'd0, 1'b0, 2'd2);
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "sb_fetch");
        cyc(0, 0, 0, 1, IR, 4'b0000, 0, 0, "sb_ex1");
        cyc(0, 1, 0, 2, RW | AS | SB, 4'b0100, 0, 0, "sb_stall");
        cyc(0, 0, 0, 2, PC | RW | AS | SB, 4'b0100, 0, 0, "sb_done");

        instr(6'b000011, 6'h00, 5'd0, 1'b1, 2'd0);
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "jal_fetch");
        cyc(0, 0, 0, 1, IR, 4'b0000, 0, 0, "jal_ex1");
        cyc(0, 0, 0, 2, PC | RF, 4'b0000, 2, 0, "jal_ex2");

        instr(6'b000000, 6'b001001, 5'd0, 1'b0, 2'd0);
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "jalr_fetch");
        cyc(0, 0, 0, 1, IR, 4'b0000, 0, 0, "jalr_ex1");
        cyc(0, 0, 0, 2, PC, 4'b0000, 0, 0, "jalr_nolink");

        instr(6'b100000, 6'h00, 5'd0, 1'b0, 2'd3);
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "lb_fetch");
        cyc(0, 0, 0, 1, IR | RR | AS | SB, 4'b1000, 0, 0, "lb_lane3");
        cyc(0, 0, 0, 2, PC | RF, 4'b0000, 0, 0, "lb_ex2");

        instr(6'b100001, 6'h00, 5'd0, 1'b0, 2'd2);
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "lh_fetch");
        cyc(0, 0, 0, 1, IR | RR | AS | SB, 4'b1100, 0, 0, "lh_lane2");
        cyc(0, 0, 0, 2, PC | RF, 4'b0000, 0, 0, "lh_ex2");

        instr(6'b111111, 6'h00, 5'd0, 1'b1, 2'd0);
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "undef_fetch");
        cyc(0, 0, 0, 1, IR, 4'b0000, 0, 0, "undef_ex1");
        cyc(0, 0, 0, 2, PC, 4'b0000, 0, 0, "undef_ex2");

        instr(6'b000001, 6'h00, 5'b10001, 1'b1, 2'd0);
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "bgezal_fetch");
        cyc(0, 0, 0, 1, IR, 4'b0000, 0, 0, "bgezal_ex1");
        cyc(0, 0, 0, 2, PC | RF, 4'b0000, 2, 0, "bgezal_ex2");

        instr(6'b000000, 6'b100001, 5'd0, 1'b0, 2'd0);
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "addu_fetch");
        cyc(0, 0, 0, 1, IR, 4'b0000, 0, 0, "addu_ex1");
        cyc(0, 0, 0, 2, PC | RF, 4'b0000, 1, 0, "addu_ex2");

        instr(6'b001101, 6'h00, 5'd0, 1'b0, 2'd0);
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "ori_fetch");
        cyc(0, 0, 0, 1, IR, 4'b0000, 0, 0, "ori_ex1");
        cyc(0, 0, 1, 2, PC | SB | RF, 4'b0000, 0, 0, "ori_halt_req");
        cyc(0, 0, 0, 3, NO, 4'b0000, 0, 0, "halted");
        cyc(0, 1, 0, 3, NO, 4'b0000, 0, 0, "halt_sticky");
        cyc(1, 0, 0, 3, NO, 4'b0000, 0, 0, "halt_reset");

        instr(6'b101001, 6'h00, 5'd0, 1'b0, 2'd1);
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "sh_fetch");
        cyc(0, 0, 0, 1, IR, 4'b0000, 0, 0, "sh_ex1");
        cyc(0, 1, 0, 2, NO, 4'b0000, 0, 0, "sh_misalign");
        cyc(0, 0, 0, 3, NO, 4'b0000, 0, 1, "sh_fault");
        cyc(0, 0, 0, 3, NO, 4'b0000, 0, 1, "sh_fault_hold");
        instr(6'b001001, 6'h00, 5'd0, 1'b0, 2'd0);
        cyc(1, 0, 0, 3, NO, 4'b0000, 0, 1, "fault_reset");
        cyc(0, 1, 0, 0, RR, 4'b1111, 0, 0, "fault_cleared");
        cyc(0, 1, 0, 0, RR, 4'b1111, 0, 0, "fetch_stall");
        cyc(1, 1, 0, 0, NO, 4'b0000, 0, 0, "reset_midstall");
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "after_reset");
        cyc(0, 0, 0, 1, IR, 4'b0000, 0, 0, "rec_ex1");
        cyc(0, 0, 0, 2, PC | SB | RF, 4'b0000, 0, 0, "rec_ex2");

        instr(6'b100011, 6'h00, 5'd0, 1'b0, 2'd2);
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "lwm_fetch");
        cyc(0, 1, 0, 1, IR, 4'b0000, 0, 0, "lw_misalign");
        cyc(0, 1, 0, 3, NO, 4'b0000, 0, 1, "lw_fault");
        cyc(1, 1, 0, 3, NO, 4'b0000, 0, 1, "lw_fault_reset");

`ifdef CTRL_WAIT_TIMEOUT_EN
        for (int i = 0; i < 4; i++)
            cyc(0, 1, 0, 0, RR, 4'b1111, 0, 0, "to_stall");
        cyc(0, 1, 0, 3, NO, 4'b0000, 0, 1, "timeout_fault");
`else
        for (int i = 0; i < 100; i++)
            cyc(0, 1, 0, 0, RR, 4'b1111, 0, 0, "long_stall");
        cyc(0, 0, 0, 0, RR, 4'b1111, 0, 0, "stall_end");
        cyc(0, 0, 0, 1, IR, 4'b0000, 0, 0, "stall_ex1");
`endif

        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
